// File: rtl/lfsr_burst_ctrl.sv
// -----------------------------------------------------------------------------
// lfsr_burst_ctrl
//   Burst sequencer around an N-bit two-tap Fibonacci-style LFSR. Software loads
//   a seed and starts a burst of len_i words. Each word is offered on a
//   valid/ready stream. The burst ends on completion, abort or LFSR lockup
//   (all-zero state).
//
// Optional feature (macro LFSR_PERIOD_DET_EN):
//   When defined, adds period_o / period_len_o. The first word of each burst is
//   captured. period_o pulses when a handshake brings the LFSR back to that word.
//   period_len_o counts handshakes since the capture.
//
// Ports
//   clk           in   1      rising-edge clock
//   reset_n       in   1      asynchronous active-low reset
//   seed_i        in   N      seed value
//   seed_load_i   in   1      load seed_i (idle only)
//   start_i       in   1      start a burst (idle only)
//   len_i         in   CNT_W  burst length in words, sampled with start_i
//   abort_i       in   1      terminate the running burst without done_o
//   out_ready_i   in   1      consumer ready
//   out_valid_o   out  1      word valid
//   out_data_o    out  N      current LFSR value
//   busy_o        out  1      controller not idle
//   done_o        out  1      one-cycle pulse at burst end (normal or lockup)
//   lockup_o      out  1      sticky: LFSR reached all-zero
//   period_o      out  1      (LFSR_PERIOD_DET_EN) LFSR returned to first word
//   period_len_o  out  CNT_W  (LFSR_PERIOD_DET_EN) handshakes since capture
// -----------------------------------------------------------------------------
module lfsr_burst_ctrl #(
    parameter int unsigned N     = 4,
    parameter int unsigned TAP_A = 1,
    parameter int unsigned TAP_B = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     seed_i,
    input  logic             seed_load_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             abort_i,
    input  logic             out_ready_i,
    output logic             out_valid_o,
    output logic [N-1:0]     out_data_o,
    output logic             busy_o,
    output logic             done_o,
`ifdef LFSR_PERIOD_DET_EN
    output logic             period_o,
    output logic [CNT_W-1:0] period_len_o,
`endif
    output logic             lockup_o
);

    localparam logic [N-1:0]     LfsrOne = N'(1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           r_state;
    logic [N-1:0]     r_lfsr;
    logic [CNT_W-1:0] r_remaining;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_lockup;

    logic [N-1:0]     w_lfsr_next;
    logic [N-1:0]     w_seed_eff;
    logic [N-1:0]     w_start_lfsr;
    logic             w_hs;

    assign w_lfsr_next  = {r_lfsr[N-2:0], r_lfsr[TAP_A] ^ r_lfsr[TAP_B]};
    // An all-zero seed would lock the LFSR immediately, so it is replaced by 1.
    assign w_seed_eff   = (seed_i == '0) ? LfsrOne : seed_i;
    // Value the burst starts from when seed load and start coincide.
    assign w_start_lfsr = seed_load_i ? w_seed_eff : r_lfsr;
    assign w_hs         = r_valid && out_ready_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_lfsr      <= LfsrOne;
            r_remaining <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_lockup    <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (seed_load_i) begin
                        r_lfsr   <= w_seed_eff;
                        r_lockup <= 1'b0;
                    end
                    if (start_i) begin
                        r_busy <= 1'b1;
                        // A zero-length burst, or a start from a locked-up LFSR, ends at
                        // once: the all-zero word is never offered.
                        if (len_i == '0 || w_start_lfsr == '0) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else begin
                            r_remaining <= len_i;
                            r_state     <= StRun;
                            r_valid     <= 1'b1;
                        end
                    end
                end

                StRun: begin
                    if (abort_i) begin
                        // Abort beats a same-cycle handshake; nothing is transferred.
                        r_state     <= StIdle;
                        r_valid     <= 1'b0;
                        r_busy      <= 1'b0;
                        r_remaining <= '0;
                    end else if (w_hs) begin
                        if (w_lfsr_next == '0) begin
                            r_lfsr      <= '0;
                            r_lockup    <= 1'b1;
                            r_state     <= StDone;
                            r_valid     <= 1'b0;
                            r_done      <= 1'b1;
                            r_remaining <= '0;
                        end else begin
                            r_lfsr      <= w_lfsr_next;
                            r_remaining <= r_remaining - CntOne;
                            if (r_remaining == CntOne) begin
                                r_state <= StDone;
                                r_valid <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end

                StDone: begin
                    r_state <= StIdle;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= StIdle;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid_o = r_valid;
    assign out_data_o  = r_lfsr;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign lockup_o    = r_lockup;

`ifdef LFSR_PERIOD_DET_EN
    logic [N-1:0]     r_capture;
    logic             r_period;
    logic [CNT_W-1:0] r_period_len;
    logic             w_burst_go;
    logic             w_run_hs;

    assign w_burst_go = (r_state == StIdle) && start_i;
    assign w_run_hs   = (r_state == StRun) && !abort_i && w_hs;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_capture    <= '0;
            r_period     <= 1'b0;
            r_period_len <= '0;
        end else if (w_burst_go) begin
            r_capture    <= w_start_lfsr;
            r_period     <= 1'b0;
            r_period_len <= '0;
        end else begin
            // The lockup word (zero) can never match, since the capture is never zero.
            r_period <= w_run_hs && (w_lfsr_next == r_capture);
            if (w_run_hs && r_period_len != '1) begin
                r_period_len <= r_period_len + CntOne;
            end
        end
    end

    assign period_o     = r_period;
    assign period_len_o = r_period_len;
`endif

endmodule
